// File: rtl/layer_pkg.sv
// Shared types and default sizing for the layer sequencing blocks.
package layer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    localparam int LAYER_NN = 10;
    localparam int LAYER_DW = 16;

endpackage

// File: rtl/layer_seq_ctrl.sv
// Gathers parallel neuron outputs of one layer and streams them, in neuron
// order, as a valid/ready serial sequence towards the next layer.
module layer_seq_ctrl
    import layer_pkg::*;
#(
    parameter int NN        = LAYER_NN,
    parameter int dataWidth = LAYER_DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           o_valid,
    input  logic [NN*dataWidth-1:0] x_out,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_in,
    output logic                    layer_done,
    output logic                    busy,
    output logic                    ovf_err
);

    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0] LAST = IW'(NN - 1);

    state_t                         state, state_nxt;
    logic [IW-1:0]                  idx, idx_nxt;
    logic [NN-1:0]                  captured, cap_nxt;
    logic [NN-1:0]                  wr_en;
    logic [NN-1:0][dataWidth-1:0]   buffer;
    logic                           xv_nxt, done_nxt, ovf_nxt;
    logic [dataWidth-1:0]           xin_nxt;

    assign busy = (state == SEND);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cap_nxt   = captured;
        wr_en     = '0;
        xv_nxt    = x_valid;
        xin_nxt   = x_in;
        done_nxt  = 1'b0;
        ovf_nxt   = err_clr ? 1'b0 : ovf_err;

        case (state)
            COLLECT: begin
                wr_en   = o_valid;
                cap_nxt = captured | o_valid;
                if (|(o_valid & captured))
                    ovf_nxt = 1'b1;
                if (&cap_nxt) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                    xv_nxt    = 1'b1;
                    // Neuron 0 may land in this very cycle; bypass the buffer.
                    xin_nxt   = o_valid[0] ? x_out[dataWidth-1:0] : buffer[0];
                end
            end
            SEND: begin
                if (|o_valid)
                    ovf_nxt = 1'b1;
                if (x_valid && out_ready) begin
                    if (idx == LAST) begin
                        state_nxt = COLLECT;
                        idx_nxt   = '0;
                        cap_nxt   = '0;
                        xv_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + IW'(1);
                        xin_nxt = buffer[idx + IW'(1)];
                    end
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= COLLECT;
            idx        <= '0;
            captured   <= '0;
            x_valid    <= 1'b0;
            x_in       <= '0;
            layer_done <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            captured   <= cap_nxt;
            x_valid    <= xv_nxt;
            x_in       <= xin_nxt;
            layer_done <= done_nxt;
            ovf_err    <= ovf_nxt;
        end
    end

    // Sample storage carries no reset; captured[] says what is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NN; i++)
            if (wr_en[i])
                buffer[i] <= x_out[i*dataWidth +: dataWidth];
    end

endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 SHALL have parameter NN, default 10, the number of neurons in the upstream layer.
REQ-002 SHALL have parameter dataWidth, default 16, the width of one neuron output.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  the reset; asynchronous and active-low.
REQ-005 SHALL have port o_valid  input  NN  per-neuron output-valid pulses from the upstream layer.
REQ-006 SHALL have port x_out  input  NN*dataWidth  upstream outputs; neuron i occupies bits [i*dataWidth +: dataWidth].
REQ-007 SHALL have port out_ready  input  1  downstream accept; tie high for an always-ready next layer.
REQ-008 SHALL have port err_clr  input  1  clears the sticky overrun flag.
REQ-009 SHALL have port x_valid  output  1  serial sample valid towards the next layer.
REQ-010 SHALL have port x_in  output  dataWidth  serial sample data towards the next layer.
REQ-011 SHALL have port layer_done  output  1  one-cycle pulse after the last sample is accepted.
REQ-012 SHALL have port busy  output  1  high while in state SEND.
REQ-013 SHALL have port ovf_err  output  1  sticky flag: a capture was dropped.

Function
REQ-014 SHALL implement two states, COLLECT and SEND, and reset into COLLECT.
REQ-015 In COLLECT, for each i with o_valid[i]=1, SHALL latch x_out slice i into buffer[i] and set captured[i].
REQ-016 SHALL capture any number of simultaneous o_valid bits in one cycle.
REQ-017 In COLLECT, a repeat o_valid[i] while captured[i]=1 SHALL overwrite buffer[i] and set ovf_err.
REQ-018 When captured becomes all-ones, SHALL enter SEND on the next edge with idx=0; this includes the case where the final bits arrive in the same cycle.
REQ-019 In SEND, SHALL drive x_valid=1 and x_in=buffer[idx], both registered; the first x_valid appears one cycle after the completing capture cycle.
REQ-020 SHALL advance idx only on x_valid&&out_ready; while out_ready=0, x_in and x_valid SHALL hold stable.
REQ-021 On acceptance at idx=NN-1, the next edge SHALL:
  - deassert x_valid;
  - pulse layer_done for exactly one cycle;
  - clear captured;
  - return to COLLECT.
REQ-022 Any o_valid bit in SEND, including the final-handshake cycle, SHALL be dropped without changing buffer and SHALL set ovf_err.
REQ-023 ovf_err SHALL stay set until err_clr=1; if err_clr and a new overrun coincide, set wins.
REQ-024 idx SHALL be $clog2(NN) bits wide and never exceed NN-1.
REQ-025 Throughput with out_ready held high SHALL be NN samples in NN consecutive cycles.

Reset
REQ-026 While rst=0, SHALL force state=COLLECT, idx=0, captured=0, x_valid=0, x_in=0, layer_done=0, busy=0, ovf_err=0.
REQ-027 Reset asserted mid-SEND SHALL abort the transfer immediately with no layer_done pulse; buffer contents need not be cleared.
REQ-028 After rst deasserts, SHALL accept captures from the first active clock edge.

Structure
REQ-029 The state enumeration and default NN and dataWidth constants SHALL live in the shared package layer_pkg.
REQ-030 SHALL be a single module with no sub-module; the capture bank is too small to justify one.

Verification
REQ-031 Staggered capture: NN=10, o_valid bits one per cycle in order 9..0 with data 0x0100+i, out_ready=1 -> x_in 0x0100..0x0109 in 10 consecutive cycles, then layer_done pulses once.
REQ-032 Simultaneous capture: all 10 o_valid bits in one cycle -> x_valid rises exactly one cycle later, and busy is high for 10 cycles.
REQ-033 Backpressure: out_ready=0 during cycles 3..5 of SEND -> x_in holds sample 3 stable, and the sequence completes with no loss or duplication.
REQ-034 Overrun: o_valid[2] pulsed twice in COLLECT (0x0011 then 0x0022), and o_valid[5] pulsed during SEND -> sample 2 reads 0x0022, buffer[5] is unchanged, ovf_err=1 until err_clr.
REQ-035 Reset mid-SEND at idx=4 -> all outputs reach their reset values asynchronously with no layer_done, and a subsequent full capture streams correctly.
